// File: rtl/i2s_sched_pkg.sv
// Shared state type, frame geometry and sample packing helpers for the
// I2S frame scheduler and its frame counter.
package i2s_sched_pkg;

   localparam int FRAME_LEN     = 512;
   localparam int CNT_W         = $clog2(FRAME_LEN);
   localparam int EOF_COUNT_DEF = 455;
   localparam int DEADLINE_DEF  = 440;

   // TX acceptance window of the controller: TX_WIN_LO..FRAME_LEN-1, then TX_WIN_HI.
   localparam int TX_WIN_LO = 456;
   localparam int TX_WIN_HI = 0;

   localparam int SAMPLE_W = 24;
   localparam int WORD_W   = 32;
   localparam int PAD_W    = WORD_W - SAMPLE_W;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RX_L     = 3'd1,
      ST_RX_R     = 3'd2,
      ST_DISPATCH = 3'd3,
      ST_WAIT_RES = 3'd4,
      ST_WAIT_WIN = 3'd5,
      ST_TX_L     = 3'd6,
      ST_TX_R     = 3'd7
   } sched_state_t;

   function automatic logic [WORD_W-1:0] pack_sample(input logic [SAMPLE_W-1:0] i_smp);
      return {{PAD_W{1'b0}}, i_smp};
   endfunction

   function automatic logic [SAMPLE_W-1:0] unpack_sample(input logic [WORD_W-1:0] i_word);
      return i_word[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/i2s_frame_counter.sv
// Free-running 9-bit I2S frame counter with decode strobes for end of frame,
// TX window start, result deadline and wrap to zero.
module i2s_frame_counter
   import i2s_sched_pkg::*;
#(
   parameter int EOF_COUNT = EOF_COUNT_DEF,
   parameter int DEADLINE  = DEADLINE_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic [CNT_W-1:0] o_count,
   output logic             o_eof,
   output logic             o_win_start,
   output logic             o_deadline,
   output logic             o_wrap
);

   localparam logic [CNT_W-1:0] L_EOF       = CNT_W'(EOF_COUNT);
   localparam logic [CNT_W-1:0] L_WIN_START = CNT_W'(EOF_COUNT + 1);
   localparam logic [CNT_W-1:0] L_DEADLINE  = CNT_W'(DEADLINE);
   localparam logic [CNT_W-1:0] L_WRAP      = CNT_W'(TX_WIN_HI);

   logic [CNT_W-1:0] r_count;

   // Runs regardless of enable so the controller's LRCK/SCLK never stall.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count     = r_count;
   assign o_eof       = (r_count == L_EOF);
   assign o_win_start = (r_count == L_WIN_START);
   assign o_deadline  = (r_count == L_DEADLINE);
   assign o_wrap      = (r_count == L_WRAP);

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Per-frame sequencer between the Pmod I2S2 AXIS controller and the ANC filter:
// pulls RX samples, dispatches them, collects the result and returns a TX packet.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no traffic; waits for enable at end of frame
// RX_L     | accepting the left RX word (a last word is taken as right)
// RX_R     | accepting the right RX word (a non-last word replaces left)
// DISPATCH | offering the captured pair to the filter core
// WAIT_RES | accepting the filter result until the deadline count
// WAIT_WIN | holding the result until the TX window opens
// TX_L     | sending the muted left TX word
// TX_R     | sending the result as the right TX word (last)
module i2s_frame_scheduler
   import i2s_sched_pkg::*;
#(
   parameter int EOF_COUNT        = EOF_COUNT_DEF,
   parameter int DEADLINE         = DEADLINE_DEF,
   parameter bit ZERO_ON_UNDERRUN = 1'b0,
   parameter int STAT_W           = 16
) (
   input  logic                axis_clk,
   input  logic                axis_resetn,
   input  logic                enable,
   output logic [CNT_W-1:0]    count,
   input  logic [WORD_W-1:0]   rx_axis_s_data,
   input  logic                rx_axis_s_valid,
   output logic                rx_axis_s_ready,
   input  logic                rx_axis_s_last,
   output logic [SAMPLE_W-1:0] smp_l_data,
   output logic [SAMPLE_W-1:0] smp_r_data,
   output logic                smp_valid,
   input  logic                smp_ready,
   input  logic [SAMPLE_W-1:0] res_data,
   input  logic                res_valid,
   output logic                res_ready,
   output logic [WORD_W-1:0]   tx_axis_m_data,
   output logic                tx_axis_m_valid,
   input  logic                tx_axis_m_ready,
   output logic                tx_axis_m_last,
   output logic [STAT_W-1:0]   underrun_cnt,
   output logic                tx_late,
   output logic                busy
);

   sched_state_t        r_state;
   sched_state_t        w_next;

   logic                w_eof;
   logic                w_win_start;
   logic                w_deadline;
   logic                w_wrap;

   logic                w_rx_hs;
   logic                w_res_hs;
   logic                w_underrun;
   logic                w_in_tx;
   logic                w_unused_pad;

   logic [SAMPLE_W-1:0] r_smp_l;
   logic [SAMPLE_W-1:0] r_smp_r;
   logic [SAMPLE_W-1:0] r_held;
   logic [SAMPLE_W-1:0] r_tx_res;
   logic [STAT_W-1:0]   r_underrun;
   logic                r_tx_late;

   i2s_frame_counter #(
      .EOF_COUNT (EOF_COUNT),
      .DEADLINE  (DEADLINE)
   ) u_frame_counter (
      .i_clk       (axis_clk),
      .i_rst_n     (axis_resetn),
      .o_count     (count),
      .o_eof       (w_eof),
      .o_win_start (w_win_start),
      .o_deadline  (w_deadline),
      .o_wrap      (w_wrap)
   );

   assign w_rx_hs      = rx_axis_s_valid & rx_axis_s_ready;
   assign w_res_hs     = res_valid & res_ready;
   assign w_underrun   = (r_state == ST_WAIT_RES) & w_deadline & ~res_valid;
   assign w_in_tx      = (r_state == ST_TX_L) | (r_state == ST_TX_R);
   assign w_unused_pad = ^rx_axis_s_data[WORD_W-1:SAMPLE_W];

   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable && w_eof) w_next = ST_RX_L;
         end
         ST_RX_L: begin
            if (w_rx_hs) w_next = rx_axis_s_last ? ST_DISPATCH : ST_RX_R;
         end
         ST_RX_R: begin
            if (w_rx_hs && rx_axis_s_last) w_next = ST_DISPATCH;
         end
         ST_DISPATCH: begin
            if (smp_ready) w_next = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            if (res_valid || w_deadline) w_next = ST_WAIT_WIN;
         end
         ST_WAIT_WIN: begin
            if (w_win_start) w_next = ST_TX_L;
         end
         ST_TX_L: begin
            if (tx_axis_m_ready) w_next = ST_TX_R;
         end
         ST_TX_R: begin
            if (tx_axis_m_ready) w_next = enable ? ST_RX_L : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_axis_s_ready = 1'b0;
      smp_valid       = 1'b0;
      res_ready       = 1'b0;
      tx_axis_m_valid = 1'b0;
      tx_axis_m_last  = 1'b0;
      tx_axis_m_data  = '0;
      case (r_state)
         ST_RX_L, ST_RX_R: rx_axis_s_ready = 1'b1;
         ST_DISPATCH:      smp_valid       = 1'b1;
         ST_WAIT_RES:      res_ready       = 1'b1;
         ST_TX_L: begin
            tx_axis_m_valid = 1'b1;
         end
         ST_TX_R: begin
            tx_axis_m_valid = 1'b1;
            tx_axis_m_last  = 1'b1;
            tx_axis_m_data  = pack_sample(r_tx_res);
         end
         default: ;
      endcase
   end

   // The last flag alone decides left vs right, whichever RX state we are in.
   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_smp_l <= '0;
         r_smp_r <= '0;
      end else if (w_rx_hs) begin
         if (rx_axis_s_last) begin
            r_smp_r <= unpack_sample(rx_axis_s_data);
         end else begin
            r_smp_l <= unpack_sample(rx_axis_s_data);
         end
      end
   end

   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_held   <= '0;
         r_tx_res <= '0;
      end else if (w_res_hs) begin
         r_held   <= res_data;
         r_tx_res <= res_data;
      end else if (w_underrun) begin
         r_tx_res <= ZERO_ON_UNDERRUN ? '0 : r_held;
      end
   end

   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_underrun <= '0;
         r_tx_late  <= 1'b0;
      end else begin
         if (w_underrun && (r_underrun != '1)) begin
            r_underrun <= r_underrun + 1'b1;
         end
         if (w_wrap && w_in_tx && !tx_axis_m_ready) begin
            r_tx_late <= 1'b1;
         end
      end
   end

   assign smp_l_data   = r_smp_l;
   assign smp_r_data   = r_smp_r;
   assign underrun_cnt = r_underrun;
   assign tx_late      = r_tx_late;
   assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Directed bench for i2s_frame_scheduler: a packet-level model predicts the
// dispatched sample pairs and TX packets, checked every cycle at the falling edge.
`timescale 1ns/1ps
module tb_i2s_frame_scheduler;

   localparam int STAT_W = 16;
   localparam bit ZOU    = 1'b0;

   logic              axis_clk;
   logic              axis_resetn;
   logic              enable;
   logic [8:0]        count;
   logic [31:0]       rx_axis_s_data;
   logic              rx_axis_s_valid;
   logic              rx_axis_s_ready;
   logic              rx_axis_s_last;
   logic [23:0]       smp_l_data;
   logic [23:0]       smp_r_data;
   logic              smp_valid;
   logic              smp_ready;
   logic [23:0]       res_data;
   logic              res_valid;
   logic              res_ready;
   logic [31:0]       tx_axis_m_data;
   logic              tx_axis_m_valid;
   logic              tx_axis_m_ready;
   logic              tx_axis_m_last;
   logic [STAT_W-1:0] underrun_cnt;
   logic              tx_late;
   logic              busy;

   i2s_frame_scheduler #(
      .EOF_COUNT        (455),
      .DEADLINE         (440),
      .ZERO_ON_UNDERRUN (ZOU),
      .STAT_W           (STAT_W)
   ) dut (
      .axis_clk        (axis_clk),
      .axis_resetn     (axis_resetn),
      .enable          (enable),
      .count           (count),
      .rx_axis_s_data  (rx_axis_s_data),
      .rx_axis_s_valid (rx_axis_s_valid),
      .rx_axis_s_ready (rx_axis_s_ready),
      .rx_axis_s_last  (rx_axis_s_last),
      .smp_l_data      (smp_l_data),
      .smp_r_data      (smp_r_data),
      .smp_valid       (smp_valid),
      .smp_ready       (smp_ready),
      .res_data        (res_data),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .tx_axis_m_data  (tx_axis_m_data),
      .tx_axis_m_valid (tx_axis_m_valid),
      .tx_axis_m_ready (tx_axis_m_ready),
      .tx_axis_m_last  (tx_axis_m_last),
      .underrun_cnt    (underrun_cnt),
      .tx_late         (tx_late),
      .busy            (busy)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [8:0]  m_count;
   logic [47:0] q_smp[$];
   logic [32:0] q_tx[$];
   logic [23:0] m_l = '0;
   logic [23:0] m_r = '0;
   logic [23:0] m_good = '0;
   int          m_underrun = 0;
   logic        stall_tx;
   logic        late_seen;
   logic        rdy_seen;

   logic        p_smp_v, p_smp_r, p_tx_v, p_tx_r;
   logic [47:0] p_smp_d;
   int          tx_l_hs_cnt = -1;
   logic [31:0] last_tx_r = '0;

   initial begin
      axis_clk = 1'b0;
      forever #5 axis_clk = ~axis_clk;
   end

   always @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) m_count <= '0;
      else              m_count <= m_count + 9'd1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (count %0d)", name, act, exp, m_count);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s (count %0d)", name, m_count);
   endtask

   task automatic tick();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic wait_cnt(input int v);
      int n = 0;
      while (m_count != v && n < 1100) begin
         tick();
         n++;
      end
      if (m_count != v) fail_now("wait_cnt timeout");
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      logic acc;
      int   n = 0;
      rx_axis_s_data  = w;
      rx_axis_s_last  = last;
      rx_axis_s_valid = 1'b1;
      do begin
         acc = rx_axis_s_ready;
         tick();
         n++;
      end while (!acc && n < 2000);
      rx_axis_s_valid = 1'b0;
      rx_axis_s_last  = 1'b0;
      if (!acc) fail_now("rx_word never accepted");
   endtask

   // Right sample is the last-flagged word; left is the word just before it, else unchanged.
   task automatic rx_packet(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2);
      logic [31:0] w [3];
      w[0] = w0;
      w[1] = w1;
      w[2] = w2;
      m_r = w[n-1][23:0];
      if (n >= 2) m_l = w[n-2][23:0];
      q_smp.push_back({m_l, m_r});
      for (int i = 0; i < n; i++) send_word(w[i], (i == n - 1));
   endtask

   task automatic give_res(input logic [23:0] v, input int at);
      logic acc;
      int   n = 0;
      wait_cnt(at);
      res_data  = v;
      res_valid = 1'b1;
      do begin
         acc = res_ready;
         tick();
         n++;
      end while (!acc && n < 20);
      res_valid = 1'b0;
      chk("res_accepted", acc, 1);
      m_good = v;
      q_tx.push_back({1'b0, 32'h0});
      q_tx.push_back({1'b1, 8'h0, v});
   endtask

   task automatic expect_underrun();
      m_underrun++;
      q_tx.push_back({1'b0, 32'h0});
      q_tx.push_back({1'b1, 8'h0, (ZOU ? 24'h0 : m_good)});
   endtask

   // Controller TX ready: open in the window 456..511 and 0 unless stalled.
   initial begin
      tx_axis_m_ready = 1'b0;
      forever begin
         tick();
         tx_axis_m_ready = ((m_count >= 9'd456) || (m_count == 9'd0)) && !stall_tx;
      end
   end

   always @(negedge axis_clk) begin
      if (!axis_resetn) begin
         p_smp_v <= 1'b0;
         p_smp_r <= 1'b0;
         p_tx_v  <= 1'b0;
         p_tx_r  <= 1'b0;
      end else begin
         chk("count", count, m_count);
         if (p_smp_v && !p_smp_r) begin
            chk("smp_valid_hold", smp_valid, 1);
            chk("smp_data_hold", {smp_l_data, smp_r_data}, p_smp_d);
         end
         if (p_tx_v && !p_tx_r) chk("tx_valid_hold", tx_axis_m_valid, 1);
         if (smp_valid && smp_ready) begin
            if (q_smp.size() == 0) fail_now("smp unexpected dispatch");
            else chk("smp_pair", {smp_l_data, smp_r_data}, q_smp.pop_front());
         end
         if (tx_axis_m_valid && tx_axis_m_ready) begin
            if (q_tx.size() == 0) fail_now("tx unexpected word");
            else chk("tx_word", {tx_axis_m_last, tx_axis_m_data}, q_tx.pop_front());
            if (!tx_axis_m_last) tx_l_hs_cnt <= int'(m_count);
            else                 last_tx_r   <= tx_axis_m_data;
         end
         p_smp_v <= smp_valid;
         p_smp_r <= smp_ready;
         p_smp_d <= {smp_l_data, smp_r_data};
         p_tx_v  <= tx_axis_m_valid;
         p_tx_r  <= tx_axis_m_ready;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      axis_resetn     = 1'b0;
      enable          = 1'b0;
      rx_axis_s_data  = '0;
      rx_axis_s_valid = 1'b0;
      rx_axis_s_last  = 1'b0;
      smp_ready       = 1'b0;
      res_valid       = 1'b0;
      res_data        = '0;
      stall_tx        = 1'b0;
      late_seen       = 1'b0;
      rdy_seen        = 1'b0;
      repeat (3) tick();
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_handshakes", {rx_axis_s_ready, smp_valid, res_ready, tx_axis_m_valid, tx_axis_m_last}, 0);
      chk("rst_samples", {smp_l_data, smp_r_data}, 0);
      chk("rst_stats", {underrun_cnt, tx_late}, 0);
      axis_resetn = 1'b1;
      enable      = 1'b1;

      // Frame 1: first packet at 456, filter slow to accept, result at count 100.
      wait_cnt(456);
      chk("first_rx_ready", rx_axis_s_ready, 1);
      rx_packet(2, 32'h00ABCDEF, 32'h00123456, 32'h0);
      repeat (3) tick();
      chk("smp_l_lit", smp_l_data, 24'hABCDEF);
      chk("smp_r_lit", smp_r_data, 24'h123456);
      chk("smp_valid_wait", smp_valid, 1);
      smp_ready = 1'b1;
      give_res(24'h7FFFFF, 100);

      // Frame 2: good result 0xAA becomes the held value.
      rx_packet(2, 32'hFF111111, 32'h00222222, 32'h0);
      chk("tx_r_lit_7fffff", last_tx_r, 32'h007FFFFF);
      give_res(24'h0000AA, 50);

      // Frame 3: result withheld past the deadline, then a late offer refused.
      rx_packet(2, 32'h00333333, 32'h00444444, 32'h0);
      chk("tx_r_lit_aa", last_tx_r, 32'h000000AA);
      wait_cnt(440);
      chk("underrun_before", underrun_cnt, 0);
      tick();
      chk("underrun_after", underrun_cnt, 1);
      expect_underrun();
      res_data  = 24'h555555;
      res_valid = 1'b1;
      repeat (5) begin
         late_seen = late_seen | res_ready;
         tick();
      end
      res_valid = 1'b0;
      chk("late_res_refused", late_seen, 0);

      // Frame 4: single last-flagged word keeps left; result exactly at deadline.
      rx_packet(1, 32'h00999999, 32'h0, 32'h0);
      chk("tx_r_substitute", last_tx_r, 32'h000000AA);
      give_res(24'h012345, 440);
      tick();
      chk("underrun_at_deadline", underrun_cnt, 1);

      // Frame 5: extra left word overwrites left; TX stalled through count 0.
      rx_packet(3, 32'h00A1A1A1, 32'hEEB2B2B2, 32'h00C3C3C3);
      chk("tx_r_deadline", last_tx_r, 32'h00012345);
      give_res(24'h0ABCDE, 100);
      stall_tx = 1'b1;
      wait_cnt(511);
      chk("tx_late_before", tx_late, 0);
      chk("tx_pending_511", tx_axis_m_valid, 1);
      repeat (2) tick();
      chk("tx_late_set", tx_late, 1);
      chk("tx_valid_kept", tx_axis_m_valid, 1);
      stall_tx = 1'b0;
      wait_cnt(458);
      chk("tx_drain_count", tx_l_hs_cnt, 456);
      chk("tx_r_drained", last_tx_r, 32'h000ABCDE);

      // Frame 6: enable dropped while waiting for the result.
      rx_packet(2, 32'h00D4D4D4, 32'h00E5E5E5, 32'h0);
      wait_cnt(20);
      enable = 1'b0;
      chk("busy_in_wait_res", busy, 1);
      give_res(24'h00BEEF, 60);
      wait_cnt(460);
      chk("idle_after_tx", busy, 0);
      chk("tx_r_final", last_tx_r, 32'h0000BEEF);
      rx_axis_s_data  = 32'h00777777;
      rx_axis_s_last  = 1'b1;
      rx_axis_s_valid = 1'b1;
      repeat (600) begin
         rdy_seen = rdy_seen | rx_axis_s_ready;
         tick();
      end
      rx_axis_s_valid = 1'b0;
      rx_axis_s_last  = 1'b0;
      chk("idle_no_rx_ready", rdy_seen, 0);
      chk("queues_drained", q_tx.size() + q_smp.size(), 0);
      chk("underrun_model", underrun_cnt, m_underrun);
      chk("tx_late_sticky", tx_late, 1);

      // Asynchronous reset in the middle of a frame while busy.
      enable = 1'b1;
      wait_cnt(456);
      rx_packet(2, 32'h00F6F6F6, 32'h00070707, 32'h0);
      wait_cnt(200);
      chk("pre_reset_busy", busy, 1);
      #1 axis_resetn = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_busy", busy, 0);
      chk("arst_handshakes", {rx_axis_s_ready, smp_valid, res_ready, tx_axis_m_valid, tx_axis_m_last}, 0);
      chk("arst_stats", {underrun_cnt, tx_late}, 0);
      chk("arst_samples", {smp_l_data, smp_r_data}, 0);
      q_tx.delete();
      q_smp.delete();
      repeat (2) tick();
      axis_resetn = 1'b1;
      repeat (5) tick();
      chk("post_reset_count", count, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Frame-level sequencer for the Pmod I2S2 AXIS controller in the ANC datapath.
- Generates the shared 9-bit I2S frame counter `count` that drives the controller's LRCK/SCLK timing.
- Each frame it pulls the 2-word RX packet from the controller and dispatches the captured samples to the ANC filter core.
- It collects the filter result, enforces a per-frame deadline with underrun substitution, and returns a 2-word TX packet in the controller's TX acceptance window.

Parameters:
- EOF_COUNT, 455, count value marking end of I2S frame (must match controller).
- DEADLINE, 440, count value by which the filter result must be received.
- ZERO_ON_UNDERRUN, 0, 1: send zero on underrun; 0: repeat last good result.
- STAT_W, 16, width of the underrun and late statistics counters.

Ports:
- axis_clk  in  1  system clock, approx 22.591 MHz.
- axis_resetn  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- count  out  9  free-running frame counter to axis_i2s2.
- rx_axis_s_data  in  32  RX packet word; bits [23:0] are the sample.
- rx_axis_s_valid  in  1  RX packet valid.
- rx_axis_s_ready  out  1  RX packet ready.
- rx_axis_s_last  in  1  RX packet last; high on the right word.
- smp_l_data  out  24  captured left sample.
- smp_r_data  out  24  captured right sample.
- smp_valid  out  1  sample valid to filter core.
- smp_ready  in  1  filter core accepts the sample.
- res_data  in  24  anti-noise result from filter core.
- res_valid  in  1  result valid.
- res_ready  out  1  scheduler accepts the result.
- tx_axis_m_data  out  32  TX packet word.
- tx_axis_m_valid  out  1  TX packet valid.
- tx_axis_m_ready  in  1  TX packet ready.
- tx_axis_m_last  out  1  TX packet last.
- underrun_cnt  out  STAT_W  count of frames with a missed deadline; saturates at max.
- tx_late  out  1  sticky flag: TX packet still pending when count wraps to 0.
- busy  out  1  state machine is not in IDLE.

Behaviour:
- Reset (async):
  - count=0; state=IDLE.
  - All valid/ready outputs 0; tx_axis_m_last=0.
  - smp_l/r_data=0; held result=0; underrun_cnt=0; tx_late=0.
- count increments every cycle, independent of enable, and wraps 511->0.
- Window: TX window is count 456..511 and 0, per the controller's ready timing.
- States:
  - IDLE: all handshakes low.
    - enable=1 and count==EOF_COUNT -> RX_L.
    - The first frame transmits nothing.
  - RX_L: rx_axis_s_ready=1.
    - On handshake with last=0: capture [23:0] into smp_l_data, go to RX_R.
    - On handshake with last=1: treat it as the right word, leave left unchanged, go to DISPATCH.
  - RX_R: rx_axis_s_ready=1.
    - On handshake: capture into smp_r_data, go to DISPATCH.
    - A word with last=0 here overwrites left and stays in RX_R.
  - DISPATCH: smp_valid=1 until smp_ready, then go to WAIT_RES.
    - smp_valid and the data stay stable while ready is low.
  - WAIT_RES: res_ready=1.
    - res_valid: latch res_data as the held result, go to WAIT_WIN.
    - count==DEADLINE without res_valid: increment underrun_cnt (saturating), select the substitute (0, or held result per ZERO_ON_UNDERRUN), go to WAIT_WIN.
    - res_valid on the same cycle as DEADLINE counts as a result; there is no underrun.
    - A late result arriving after leaving WAIT_RES is not accepted; res_ready=0.
  - WAIT_WIN: wait for count==EOF_COUNT+1, then go to TX_L.
  - TX_L: tx word = 32'h0 (left muted), last=0.
    - On handshake go to TX_R.
  - TX_R: tx word = {8'h0, result}, last=1.
    - On handshake: if enable=1 go to RX_L, else go to IDLE.
- tx_axis_m_valid is held until the handshake and never withdrawn.
- tx_late is set if count==0 while in TX_L/TX_R and valid is not yet accepted. The packet stays pending and drains in the next window.
- Latency: a sample received in frame N's window is transmitted in frame N+1's window. Fixed at one frame.
- enable deassert mid-operation completes the current packet, then returns to IDLE.
- Statistics are cleared only by reset.

Decomposition:
- Package i2s_sched_pkg holds:
  - state enum;
  - FRAME_LEN=512;
  - EOF_COUNT default;
  - TX window bounds (456, 0);
  - word-packing constants for the 24-bit sample in a 32-bit word.
- One sub-module, i2s_frame_counter: 9-bit counter plus window/EOF/DEADLINE decode strobes.

Test Plan:
- Reset mid-frame at count=200 -> count=0, all valids/readies 0, underrun_cnt=0 within the same cycle (async).
- enable=1, RX words 0x00ABCDEF/last=0 and 0x00123456/last=1 at count 456; filter returns 0x7FFFFF at count 100 -> smp_l=ABCDEF, smp_r=123456; next frame TX words 0x00000000 then 0x007FFFFF with last=1.
- Filter withholds res_valid, ZERO_ON_UNDERRUN=0, prior result 0x0000AA -> at count 440 underrun_cnt goes 0->1; TX right word 0x000000AA.
- res_valid asserted exactly at count==DEADLINE -> result 0x012345 sent, underrun_cnt unchanged.
- tx_axis_m_ready held low through count 0 -> tx_late=1, valid stays high, packet sent at next count 456.
- enable dropped during WAIT_RES -> TX packet still completes, then busy=0 and IDLE with no further rx_axis_s_ready.
